// File: rtl/mcpu_mem_pkg.sv
// mcpu_mem_pkg: shared RAM write-size codes, ownership states and port ids
package mcpu_mem_pkg;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_B1 = 2'b01;
  localparam logic [1:0] WR_B4 = 2'b10;
  localparam logic [1:0] WR_B8 = 2'b11;
  typedef enum logic [1:0] {OPEN = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_e;
  localparam logic P_CPU = 1'b0;
  localparam logic P_HOST = 1'b1;
endpackage

// File: rtl/arb_rdpipe.sv
// arb_rdpipe: LAT-deep {valid, port id} shift register steering read returns
module arb_rdpipe
  import mcpu_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic port_i,
  output logic rvalid0_o,
  output logic rvalid1_o,
  output logic busy_o
);
  logic [LAT-1:0] v_q, p_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      p_q <= '0;
    end else begin
      v_q <= (v_q << 1) | LAT'(valid_i);
      p_q <= (p_q << 1) | LAT'(port_i);
    end
  assign rvalid0_o = v_q[LAT-1] & (p_q[LAT-1] == P_CPU);
  assign rvalid1_o = v_q[LAT-1] & (p_q[LAT-1] == P_HOST);
  assign busy_o = |v_q;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin CPU/host arbiter for the shared 64-bit RAM.
// Define ARB_LOCK_EN to enable the ownership lock for read-modify-write sequences.
module ram_arbiter
  import mcpu_mem_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 64,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    wr0,
  input  logic [1:0]    wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_load,
  output logic [1:0]    ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);
  logic allow0, allow1, xfer, last_q, last_d, rd_q, rd_d, rdp_q, load_d, pipe_busy;
  logic [1:0] wr_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] d_d;
`ifdef ARB_LOCK_EN
  own_e own_q, own_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) own_q <= OPEN;
    else own_q <= own_d;
  always_comb
    own_d = (own_q == OPEN) ? (gnt0 & lock0 ? OWN0 : gnt1 & lock1 ? OWN1 : OPEN)
          : (own_q == OWN0) ? (((gnt0 | ~req0) & ~lock0) ? OPEN : OWN0)
          : (((gnt1 | ~req1) & ~lock1) ? OPEN : OWN1);
  always_comb begin
    allow0 = own_q != OWN1;
    allow1 = own_q != OWN0;
  end
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  assign allow0 = 1'b1;
  assign allow1 = 1'b1;
`endif
  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt0 = allow0 & req0 & (~(allow1 & req1) | (last_q == P_HOST));
    gnt1 = allow1 & req1 & (~(allow0 & req0) | (last_q == P_CPU));
  end
  always_comb begin
    xfer = gnt0 | gnt1;
    last_d = xfer ? (gnt1 ? P_HOST : P_CPU) : last_q;
    load_d = xfer & (gnt1 ? we1 : we0);
    wr_d = load_d ? (gnt1 ? wr1 : wr0) : WR_NONE;
    addr_d = xfer ? (gnt1 ? addr1 : addr0) : ram_addr;
    d_d = xfer ? (gnt1 ? wdata1 : wdata0) : ram_d;
    rd_d = xfer & ~load_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= P_HOST;
      ram_load <= 1'b0;
      ram_wr <= WR_NONE;
      ram_addr <= '0;
      ram_d <= '0;
      rd_q <= 1'b0;
      rdp_q <= P_CPU;
    end else begin
      last_q <= last_d;
      ram_load <= load_d;
      ram_wr <= wr_d;
      ram_addr <= addr_d;
      ram_d <= d_d;
      rd_q <= rd_d;
      rdp_q <= gnt1;
    end
  // The pipe starts at the issue cycle, so data arrives LAT cycles after the RAM sees the command.
  arb_rdpipe #(.LAT(LAT)) u_rdpipe (
    .clk(clk),
    .rst(rst),
    .valid_i(rd_q),
    .port_i(rdp_q),
    .rvalid0_o(rvalid0),
    .rvalid1_o(rvalid1),
    .busy_o(pipe_busy)
  );
  assign rdata0 = rvalid0 ? ram_q : '0;
  assign rdata1 = rvalid1 ? ram_q : '0;
  assign busy = ram_load | rd_q | pipe_busy;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter with LAT=1 and LAT=3 instances
module tb_ram_arbiter;
`ifdef ARB_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [1:0] wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_load, busy;
  logic [63:0] rdata0, rdata1, ram_d, ram_q;
  logic [1:0] ram_wr;
  logic [15:0] ram_addr;
  logic gnt0_3, gnt1_3, rvalid0_3, rvalid1_3, ram_load_3, busy_3;
  logic [63:0] rdata0_3, rdata1_3, ram_d_3, ram_q_3;
  logic [1:0] ram_wr_3;
  logic [15:0] ram_addr_3;
  logic [63:0] q3 [3];
  int checks = 0, failures = 0;

  ram_arbiter #(.AW(16), .DW(64), .LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ram_load(ram_load), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_q(ram_q), .busy(busy));

  ram_arbiter #(.AW(16), .DW(64), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0_3), .gnt1(gnt1_3), .rvalid0(rvalid0_3), .rvalid1(rvalid1_3),
    .rdata0(rdata0_3), .rdata1(rdata1_3), .ram_load(ram_load_3), .ram_wr(ram_wr_3), .ram_addr(ram_addr_3),
    .ram_d(ram_d_3), .ram_q(ram_q_3), .busy(busy_3));

  function automatic logic [63:0] mem(input logic [15:0] a);
    return (a == 16'h0010) ? 64'h1122334455667788 : {a, ~a, a ^ 16'hA5A5, 16'h0F0F};
  endfunction

  always #5 clk = ~clk;
  always_ff @(posedge clk) ram_q <= mem(ram_addr);
  always_ff @(posedge clk) begin
    q3[0] <= mem(ram_addr_3);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign ram_q_3 = q3[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, {gnt0, gnt1, gnt0_3, gnt1_3}, 0);
    check({tag, "_rv"}, {rvalid0, rvalid1, rvalid0_3, rvalid1_3}, 0);
    check({tag, "_busy"}, {busy, busy_3}, 0);
    check({tag, "_load"}, {ram_load, ram_load_3}, 0);
    check({tag, "_wr"}, {ram_wr, ram_wr_3}, 0);
    check({tag, "_addr"}, {ram_addr, ram_addr_3}, 0);
    check({tag, "_d"}, ram_d, 0);
    check({tag, "_rdata"}, rdata0 | rdata1, 0);
  endtask

  initial begin
    {req0, req1, we0, we1, lock0, lock1} = '0;
    {wr0, wr1} = '0;
    {addr0, addr1} = '0;
    {wdata0, wdata1} = '0;
    @(negedge clk);
    check_zero("rst");
    next_cycle();
    rst = 1'b0;
    addr0 = 16'h0020;
    addr1 = 16'h0028;
    for (int i = 0; i < 8; i++) begin
      req0 = i < 6;
      req1 = i < 6;
      @(negedge clk);
      check("cont_gnt", {gnt0, gnt1}, i < 6 ? (i % 2 == 0 ? 2'b10 : 2'b01) : 2'b00);
      if (i >= 2) begin
        check("cont_rv", {rvalid0, rvalid1}, i % 2 == 0 ? 2'b10 : 2'b01);
        check("cont_rd", i % 2 == 0 ? rdata0 : rdata1, mem(i % 2 == 0 ? 16'h0020 : 16'h0028));
      end
      next_cycle();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    addr0 = 16'h0010;
    req0 = 1'b1;
    @(negedge clk);
    check("rd_gnt", {gnt0, gnt1}, 2'b10);
    check("rd_idle_busy", busy, 0);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("rd_addr", ram_addr, 16'h0010);
    check("rd_load", {ram_load, ram_wr}, 0);
    check("rd_busy", busy, 1);
    check("rd_early_rv", rvalid0, 0);
    next_cycle();
    @(negedge clk);
    check("rd_rv", {rvalid0, rvalid1}, 2'b10);
    check("rd_data", rdata0, 64'h1122334455667788);
    next_cycle();
    we1 = 1'b1;
    addr1 = 16'h0100;
    wdata1 = 64'hAABBCCDDEEFF0011;
    for (int i = 0; i < 6; i++) begin
      req1 = i < 4;
      wr1 = 2'(i + 1);
      @(negedge clk);
      check("wr_gnt", {gnt0, gnt1}, i < 4 ? 2'b01 : 2'b00);
      check("wr_load", ram_load, i >= 1 && i <= 4);
      check("wr_size", ram_wr, (i >= 1 && i <= 4) ? 2'(i) : 2'b00);
      check("wr_rv", {rvalid0, rvalid1}, 0);
      if (i >= 1 && i <= 4) begin
        check("wr_addr", ram_addr, 16'h0100);
        check("wr_data", ram_d, 64'hAABBCCDDEEFF0011);
      end
      next_cycle();
    end
    addr0 = 16'h0050;
    addr1 = 16'h0040;
    wr1 = 2'b11;
    for (int i = 0; i < 7; i++) begin
      req1 = i == 0 || i == 3;
      we1 = i == 3;
      lock1 = i < 3;
      req0 = i >= 1 && i <= 4;
      @(negedge clk);
      check("lock_gnt", {gnt0, gnt1},
            (i == 0 || i == 3) ? 2'b01 : (i == 1 || i == 2) ? {!LK, 1'b0} : i == 4 ? 2'b10 : 2'b00);
      next_cycle();
    end
    {req0, req1, we0, we1, lock0, lock1} = '0;
    repeat (6) next_cycle();
    for (int i = 0; i < 10; i++) begin
      req0 = i < 4;
      addr0 = 16'h0200 + 16'(8 * i);
      @(negedge clk);
      check("b2b_rv", rvalid0_3, i >= 4 && i <= 7);
      check("b2b_rv1", rvalid1_3, 0);
      check("b2b_busy", busy_3, i >= 1 && i <= 7);
      if (i >= 4 && i <= 7) check("b2b_rd", rdata0_3, mem(16'h0200 + 16'(8 * (i - 4))));
      next_cycle();
    end
    addr0 = 16'h0300;
    addr1 = 16'h0308;
    req0 = 1'b1;
    req1 = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check_zero("mid_rst");
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rv", {rvalid0, rvalid1, rvalid0_3, rvalid1_3}, 0);
      check("post_rst_busy", {busy, busy_3}, 0);
      next_cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single 64-bit main RAM between the CPU core (port 0) and a host/loader port (port 1, program download and debug readback). It accepts one command per cycle, issues it to the RAM through registered outputs, and routes read data back to the requester that issued it. Round-robin fairness is the default. An optional lock lets a requester hold exclusive ownership across a read-modify-write sequence.

## Interface
- AW, 16, RAM byte-address width; matches the RAM's 16-bit address.
- DW, 64, data width.
- LAT, 1, RAM read latency in cycles from command to valid `ram_q` (1..4).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0 / req1  in  1  command request; held high until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- wr0 / wr1  in  2  write size code: 01 = 1 byte, 10 = 4 bytes, 11 = 8 bytes, 00 = none.
- addr0 / addr1  in  AW  byte address.
- wdata0 / wdata1  in  DW  write data.
- lock0 / lock1  in  1  keep ownership after this grant (only effective with ARB_LOCK_EN).
- gnt0 / gnt1  out  1  combinational; command accepted at the coming edge.
- rvalid0 / rvalid1  out  1  one-cycle pulse; read data valid.
- rdata0 / rdata1  out  DW  read data; equals `ram_q` while the matching rvalid is high.
- ram_load  out  1  registered write enable to the RAM.
- ram_wr  out  2  registered size code.
- ram_addr  out  AW  registered address.
- ram_d  out  DW  registered write data.
- ram_q  in  DW  RAM read data.
- busy  out  1  high while a command is issued or any read is in flight.

## Operation
- Handshake: a command transfers at the edge where reqN=1 and gntN=1. At most one of gnt0/gnt1 is high in any cycle. gnt is never high without the matching req.
- Arbitration state `last` holds the last winner.
  - Single requester: that requester wins.
  - Both requesting: the port other than `last` wins.
  - `last` updates on every transfer.
- Ownership FSM, with ARB_LOCK_EN only. States are OPEN, OWN0 and OWN1.
  - OPEN → OWNn: on a port-n transfer with lockn=1.
  - OWNn: only port n can be granted.
  - OWNn → OPEN: on a port-n transfer with lockn=0, or when lockn is sampled low while reqn=0.
- Issue register: on each transfer, the command is loaded for exactly one cycle.
  - ram_load = we, ram_wr = wr, and ram_addr / ram_d are loaded.
  - Reads set ram_load = 0 and ram_wr = 00.
  - With no transfer, ram_load = 0 and ram_wr = 00 in the following cycle; addr and data hold their previous values.
- Write with wr = 00: granted and issued with ram_load = 1 and ram_wr = 00. The RAM performs no write and no rvalid is produced.
- Read return: a LAT-deep owner pipeline (valid bit + port id) tracks each read. The matching rvalid pulses exactly when the entry exits; the other port's rvalid stays 0.
- Reads and writes may interleave back-to-back. Returns arrive strictly in issue order.
- busy = ram_load | any command issued this cycle | any valid pipeline entry.

## Timing
- Command latency: transfer at edge k → RAM command visible in cycle k+1 → read data and rvalid in cycle k+1+LAT.
- Throughput: one command per cycle. A single port that keeps req high is granted every cycle when uncontested.
- Contention: with both ports requesting continuously, grants alternate 0, 1, 0, 1, … (OPEN state).
- Reset values:
  - all gnt and rvalid = 0, busy = 0
  - ram_load = 0, ram_wr = 00, ram_addr = 0, ram_d = 0, rdata = 0
  - `last` = 1, so port 0 wins the first tie
  - FSM = OPEN; owner pipeline cleared.
- Reset mid-operation discards in-flight reads (no rvalid) and drops any lock. Requesters must reissue.

## Configuration
- ARB_LOCK_EN defined: the ownership FSM above is active.
- ARB_LOCK_EN undefined:
  - lock0 and lock1 are ignored; the ports remain present.
  - The FSM is removed, and arbitration is always pure round-robin.

## Structure
- Shared package `mcpu_mem_pkg` holds:
  - wr size codes WR_NONE = 2'b00, WR_B1 = 2'b01, WR_B4 = 2'b10, WR_B8 = 2'b11
  - ownership state encodings OPEN, OWN0 and OWN1
  - port id constants P_CPU = 0, P_HOST = 1.
- One sub-module, `arb_rdpipe`: a LAT-deep shift register of {valid, port id} that outputs per-port rvalid.

## Test plan
- Reset: assert rst mid-stream with reads in flight → all outputs zero; no rvalid during the following 4 cycles after release.
- Single read: port 0 reads addr 0x0010 while the RAM holds 0x1122334455667788 at that address, LAT = 1 → gnt0 in cycle k; ram_addr = 0x0010 and ram_load = 0 in k+1; rvalid0 = 1 and rdata0 = 0x1122334455667788 in k+2; rvalid1 stays 0.
- Contention: both ports hold reads for 6 cycles → grants alternate 0,1,0,1,0,1, and each rvalid pulses three times in issue order.
- Write sizes: port 1 writes 0xAABBCCDDEEFF0011 to 0x0100 with wr = 01, then 10, then 11 → ram_load = 1 with the matching ram_wr each cycle, and no rvalid.
- Lock (ARB_LOCK_EN): port 1 reads 0x0040 with lock1 = 1, then port 0 requests → port 0 is blocked until port 1 writes 0x0040 with lock1 = 0; port 0 is granted the next cycle.
- Back-to-back with LAT = 3: port 0 issues 4 consecutive reads → 4 consecutive rvalid0 pulses starting 4 cycles after the first transfer, and busy drops one cycle after the last pulse.
